// File: rtl/dmstore_buf.sv
// Store buffer for the MEM stage: lane-encodes stores and drains them to data memory in order.
// Define STORE_FWD_EN to build the load/store address comparators behind ld_hit.
`ifndef WM_WD
`define WM_WD 3'd0
`define WM_HS 3'd1
`define WM_HU 3'd2
`define WM_BS 3'd3
`define WM_BU 3'd4
`endif

module dmstore_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       wordmode,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             misalign,
    output logic [CNT_W-1:0] pending,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]      e_addr  [DEPTH];
    logic [31:0]      e_wdata [DEPTH];
    logic [3:0]       e_be    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic        legal;
    logic [3:0]  enc_be;
    logic [31:0] enc_wdata;
    logic        accept;
    logic        push;
    logic        pop;

    // Lane encoding of the incoming store; undefined width codes are illegal.
    always_comb begin
        legal     = 1'b0;
        enc_be    = 4'b0000;
        enc_wdata = 32'h0;
        case (wordmode)
            `WM_WD: begin
                legal     = (st_addr[1:0] == 2'b00);
                enc_be    = 4'b1111;
                enc_wdata = st_data;
            end
            `WM_HS, `WM_HU: begin
                legal     = !st_addr[0];
                enc_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                enc_wdata = {2{st_data[15:0]}};
            end
            `WM_BS, `WM_BU: begin
                legal     = 1'b1;
                enc_be    = 4'b0001 << st_addr[1:0];
                enc_wdata = {4{st_data[7:0]}};
            end
            default: legal = 1'b0;
        endcase
    end

    assign st_ready  = (count != CNT_W'(DEPTH));
    assign mem_req   = (count != '0);
    assign accept    = st_valid && st_ready;
    assign push      = accept && legal;
    assign pop       = mem_req && mem_ack;
    assign pending   = count;
    assign mem_addr  = {e_addr[rd_ptr], 2'b00};
    assign mem_wdata = e_wdata[rd_ptr];
    assign mem_be    = e_be[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_addr[i]  <= '0;
                e_wdata[i] <= '0;
                e_be[i]    <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= accept && !legal;
            if (push) begin
                e_addr[wr_ptr]  <= st_addr[31:2];
                e_wdata[wr_ptr] <= enc_wdata;
                e_be[wr_ptr]    <= enc_be;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] fwd_offs;

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        ld_hit   = 1'b0;
        fwd_offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_offs = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(fwd_offs) < count) && (e_addr[i] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign ld_hit         = 1'b0;
`endif

endmodule
